// File: rtl/multicycle_controller.sv
// Main control FSM for a multicycle RV32I datapath: sequences FETCH/DECODE and the
// per-class execute states, driving datapath selects and write enables each cycle.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       lt,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [2:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] fsm_state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // sub_ok is only set for register-register ops; immediates never subtract.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        case (f3)
            3'b000:  return sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: state_d = S_MEMWB;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_JALR:    state_d = S_JAL;
            S_JAL:     state_d = S_ALUWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ImmSrc     = 3'b000;
        ALUControl = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_JAL) ? 3'b100 : 3'b010;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_STORE) ? 3'b001 : 3'b000;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_decode(funct3, funct7_5);
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_decode(funct3, 1'b0);
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                ImmSrc     = 3'b010;
                case (funct3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    3'b100:  PCWrite = lt;
                    3'b101:  PCWrite = ~lt;
                    default: PCWrite = 1'b0;
                endcase
            end
            S_JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_JAL: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            S_LUI: begin
                ImmSrc    = 3'b011;
                ResultSrc = 2'b11;
                RegWrite  = 1'b1;
            end
            default: ;
        endcase
        // Reset holds the state in FETCH, which would otherwise enable writes.
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: a per-instruction model
// queues the expected per-cycle control vector and a negedge monitor checks it.
module tb_multicycle_controller;

    localparam int W = 21;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
        S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6,
        S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10,
        S_JALR = 4'd11, S_LUI = 4'd12;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
        XOR_ = 3'd4, SLT = 3'd5, SLTU = 3'd6;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
        IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111,
        LU = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5, zero, lt;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ImmSrc, ALUControl;
    logic [3:0] fsm_state;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           total = 0;
    int           bad = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .zero(zero), .lt(lt), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] mk(input logic [3:0] st, input logic pcw,
        input logic irw, input logic mw, input logic rw, input logic adr,
        input logic [1:0] asa, input logic [1:0] asb, input logic [1:0] rs,
        input logic [2:0] imm, input logic [2:0] alu);
        return {st, pcw, irw, mw, rw, adr, asa, asb, rs, imm, alu};
    endfunction

    // Arithmetic/logic op named by the mnemonic behind funct3.
    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic is_sub);
        case (f3)
            3'd0:    return is_sub ? SUB : ADD;
            3'd2:    return SLT;
            3'd3:    return SLTU;
            3'd4:    return XOR_;
            3'd6:    return OR_;
            3'd7:    return AND_;
            default: return ADD;
        endcase
    endfunction

    // Branch outcome from the compared operands themselves, not the flags.
    function automatic logic taken(input logic [2:0] f3, input logic [31:0] a,
        input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic push(input logic [W-1:0] v, input string nm);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic push_head(input logic [6:0] o, input string tag);
        push(mk(S_FETCH, 1, 1, 0, 0, 0, 2'd0, 2'd2, 2'd2, 3'd0, ADD), {tag, ".fetch"});
        push(mk(S_DECODE, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, (o == JL) ? 3'd4 : 3'd2, ADD),
             {tag, ".decode"});
    endtask

    task automatic push_alu_wb(input string tag);
        push(mk(S_ALUWB, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, ADD), {tag, ".aluwb"});
    endtask

    task automatic push_jal(input string tag);
        push(mk(S_JAL, 1, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 3'd0, ADD), {tag, ".jal"});
        push_alu_wb(tag);
    endtask

    task automatic model(input logic [6:0] o, input logic [2:0] f3, input logic f75,
        input logic [31:0] a, input logic [31:0] b, input string tag);
        push_head(o, tag);
        case (o)
            LW: begin
                push(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, ADD), {tag, ".memadr"});
                push(mk(S_MEMREAD, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, ADD), {tag, ".memread"});
                push(mk(S_MEMWB, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 3'd0, ADD), {tag, ".memwb"});
            end
            SW: begin
                push(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd1, ADD), {tag, ".memadr"});
                push(mk(S_MEMWRITE, 0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, ADD), {tag, ".memwrite"});
            end
            RT: begin
                push(mk(S_EXECR, 0, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd0, alu_of(f3, f75)),
                     {tag, ".execr"});
                push_alu_wb(tag);
            end
            IT: begin
                push(mk(S_EXECI, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, alu_of(f3, 1'b0)),
                     {tag, ".execi"});
                push_alu_wb(tag);
            end
            BR: push(mk(S_BRANCH, taken(f3, a, b), 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 3'd2, SUB),
                     {tag, ".branch"});
            JL: push_jal(tag);
            JR: begin
                push(mk(S_JALR, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, ADD), {tag, ".jalr"});
                push_jal(tag);
            end
            LU: push(mk(S_LUI, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 3'd3, ADD), {tag, ".lui"});
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    // Returns at the posedge that follows the last queued cycle.
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got=%0d pending want=0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Entered at posedge+1 with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75,
        input logic [31:0] a, input logic [31:0] b, input string tag);
        op       = o;
        funct3   = f3;
        funct7_5 = f75;
        zero     = (a == b);
        lt       = ($signed(a) < $signed(b));
        model(o, f3, f75, a, b, tag);
        wait_drain();
        #1;
    endtask

    function automatic logic legal(input logic [6:0] o);
        return o inside {LW, SW, RT, IT, BR, JL, JR, LU};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && exp_q.size() != 0) begin
            logic [W-1:0] want;
            logic [W-1:0] got;
            string        nm;
            want = exp_q.pop_front();
            nm   = name_q.pop_front();
            got  = {fsm_state, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc,
                    ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s: got=%06h want=%06h", nm, got, want);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] ops[8];
        rst = 1'b1;
        op = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0;
        ops = '{LW, SW, RT, IT, BR, JL, JR, LU};

        repeat (3) @(posedge clk);
        #1;
        check("reset_write_enables", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        check("reset_state", fsm_state, S_FETCH);
        @(posedge clk);
        #1 rst = 1'b0;

        run_instr(LW, 3'd2, 1'b0, 32'd4, 32'd8, "lw");
        run_instr(RT, 3'd0, 1'b1, 32'd5, 32'd3, "sub");
        run_instr(RT, 3'd0, 1'b0, 32'd5, 32'd3, "add");
        run_instr(BR, 3'd0, 1'b0, 32'd7, 32'd7, "beq_taken");
        run_instr(BR, 3'd0, 1'b0, 32'd7, 32'd9, "beq_not");
        run_instr(BR, 3'd5, 1'b0, 32'hFFFF_FFFF, 32'd1, "bge_lt");
        run_instr(BR, 3'd5, 1'b0, 32'd9, 32'd1, "bge_ge");
        run_instr(JR, 3'd0, 1'b0, 32'd0, 32'd1, "jalr");
        run_instr(JL, 3'd0, 1'b0, 32'd0, 32'd1, "jal");
        run_instr(LU, 3'd0, 1'b0, 32'd0, 32'd1, "lui");
        run_instr(IT, 3'd0, 1'b1, 32'd0, 32'd1, "addi_f7");

        // Store interrupted by reset while MemWrite is high.
        op = SW; funct3 = 3'd2; funct7_5 = 1'b0; zero = 1'b0; lt = 1'b0;
        push_head(SW, "sw_rst");
        push(mk(S_MEMADR, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd1, ADD), "sw_rst.memadr");
        wait_drain();
        #1;
        check("sw_memwrite_high", MemWrite, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("sw_rst_memwrite_low", MemWrite, 1'b0);
        check("sw_rst_state", fsm_state, S_FETCH);
        @(posedge clk);
        #1 rst = 1'b0;
        run_instr(7'b0000000, 3'd0, 1'b0, 32'd0, 32'd1, "illegal0");

        for (int i = 0; i < 120; i++) begin
            logic [6:0]  o;
            logic [31:0] a, b;
            if ($urandom_range(0, 9) == 0) begin
                o = 7'($urandom_range(0, 127));
                while (legal(o)) o = 7'($urandom_range(0, 127));
            end else begin
                o = ops[$urandom_range(0, 7)];
            end
            a = $urandom();
            b = ($urandom_range(0, 3) == 0) ? a : $urandom();
            run_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b,
                      $sformatf("rnd%0d_op%02h", i, o));
        end
        run_instr(7'b1111111, 3'd0, 1'b0, 32'd0, 32'd0, "illegal_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 op  input  7  instruction[6:0] from the instruction register.
REQ-005 funct3  input  3  instruction[14:12].
REQ-006 funct7_5  input  1  instruction[30].
REQ-007 zero  input  1  ALU result == 0.
REQ-008 lt  input  1  ALU signed-less-than flag for the current subtract.
REQ-009 PCWrite, IRWrite, MemWrite, RegWrite  output  1 each  write enables.
REQ-010 AdrSrc  output  1  memory address: 0 = PC, 1 = ALUOut register.
REQ-011 ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A register.
REQ-012 ALUSrcB  output  2  00 = B register, 01 = ImmExt, 10 = constant 4.
REQ-013 ResultSrc  output  2  00 = ALUOut, 01 = Data register, 10 = ALUResult, 11 = ImmExt.
REQ-014 ImmSrc  output  3  immediate-extender select: 000 I, 001 S, 010 B, 011 U, 100 J.
REQ-015 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sltu.

Function
REQ-016 The controller SHALL be a Moore FSM, except that PCWrite in BRANCH depends on zero, lt, and funct3.
REQ-017 In every state, any output not listed SHALL be 0.
REQ-018 FETCH SHALL assert IRWrite and PCWrite, with AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUControl=add, and ResultSrc=10; next state is DECODE.
REQ-019 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, and ALUControl=add, so that the target is latched into ALUOut.
REQ-020 In DECODE, ImmSrc SHALL be 100 when op=1101111 and 010 otherwise.
REQ-021 DECODE SHALL branch on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BRANCH
- 1101111 -> JAL
- 1100111 -> JALR
- 0110111 -> LUI
- any other op -> FETCH, with no architectural write.
REQ-022 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, and add.
REQ-023 In MEMADR, ImmSrc SHALL be 000 for a load and 001 for a store; next state is MEMREAD for a load and MEMWRITE for a store.
REQ-024 MEMREAD SHALL drive AdrSrc=1 and go to MEMWB.
REQ-025 MEMWB SHALL drive ResultSrc=01 and RegWrite=1, then go to FETCH.
REQ-026 MEMWRITE SHALL drive AdrSrc=1 and MemWrite=1, then go to FETCH.
REQ-027 EXECR SHALL drive ALUSrcA=10 and ALUSrcB=00, then go to ALUWB.
REQ-028 EXECI SHALL drive ALUSrcA=10, ALUSrcB=01, and ImmSrc=000, then go to ALUWB.
REQ-029 ALUControl in EXECR and EXECI SHALL decode funct3 as follows:
- 000 -> add, or sub only when in EXECR with funct7_5=1
- 010 -> slt
- 011 -> sltu
- 100 -> xor
- 110 -> or
- 111 -> and
- other values -> add.
REQ-030 ALUWB SHALL drive ResultSrc=00 and RegWrite=1, then go to FETCH.
REQ-031 BRANCH SHALL drive ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, and ImmSrc=010, then go to FETCH.
REQ-032 PCWrite in BRANCH SHALL be asserted as follows:
- funct3 000 (beq) -> zero
- 001 (bne) -> !zero
- 100 (blt) -> lt
- 101 (bge) -> !lt
- other values -> 0.
REQ-033 JALR SHALL drive ALUSrcA=10, ALUSrcB=01, ImmSrc=000, and add, then go to JAL.
REQ-034 JAL SHALL drive PCWrite=1, ResultSrc=00, ALUSrcA=01, ALUSrcB=10, and add (OldPC+4), then go to ALUWB.
REQ-035 LUI SHALL drive ImmSrc=011, ResultSrc=11, and RegWrite=1, then go to FETCH.
REQ-036 Instruction latency in cycles, counting FETCH, SHALL be:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type / I-type ALU | 4 |
| branch | 3 |
| jal | 4 |
| jalr | 5 |
| lui | 3 |
| illegal | 2 |

REQ-037 The state register SHALL be the only storage element.
REQ-038 Unreachable state encodings SHALL return to FETCH on the next edge.

Reset
REQ-039 Asserting rst SHALL force the state to FETCH immediately, independent of clk, including mid-instruction.
REQ-040 While rst=1, PCWrite, IRWrite, MemWrite, and RegWrite SHALL be forced to 0.
REQ-041 The first rising clk edge after rst falls SHALL execute FETCH.

Verification
REQ-042 lw (op=0000011) after reset: the bench SHALL see the state sequence FETCH, DECODE, MEMADR (ImmSrc=000), MEMREAD (AdrSrc=1), MEMWB (RegWrite=1, ResultSrc=01), then FETCH.
REQ-043 R-type sub (op=0110011, funct3=000, funct7_5=1): EXECR SHALL show ALUControl=001.
REQ-044 The same R-type encoding with funct7_5=0 SHALL show ALUControl=000.
REQ-045 ALUWB SHALL show RegWrite=1, giving 4 cycles total for the R-type instruction.
REQ-046 beq (funct3=000) with zero=1 SHALL give PCWrite=1 in BRANCH; with zero=0, PCWrite=0.
REQ-047 bge (funct3=101) with lt=1 SHALL give PCWrite=0; with lt=0, PCWrite=1; each branch takes 3 cycles.
REQ-048 jalr SHALL run FETCH, DECODE, JALR (ImmSrc=000), JAL (PCWrite=1, ALUSrcB=10), ALUWB, then FETCH.
REQ-049 jal SHALL show ImmSrc=100 in DECODE.
REQ-050 Asserting rst mid-MEMWRITE SHALL drop MemWrite to 0 within the same cycle and put the state in FETCH.
REQ-051 After the REQ-050 reset, illegal op=0000000 SHALL run FETCH, DECODE, FETCH with no write enable asserted.
